// File: rtl/prbs_stream_checker.sv
// prbs_stream_checker
//
// Receive-end checker for a Galois-LFSR pseudo-random word stream arriving
// on a valid/ready sink. In SEARCH it seeds a reference from each received
// word and locks once LOCK_CNT consecutive words follow the LFSR step rule.
// In LOCKED the reference free-runs and every accepted word is compared
// against it. Mismatches are counted (saturating) and LOSS_CNT consecutive
// mismatches drop back to SEARCH.
//
// Handshake: a beat is transferred on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid. Nothing changes on cycles without a beat.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    input word valid
//   s_ready    checker ready (constant 1 unless halted)
//   s_data     received word, DATA_W bits
//   clr_cnt    synchronous clear of err_cnt/beat_cnt (and the halt flag)
//   locked     high while the checker is in LOCKED (the FSM state itself)
//   err_pulse  registered one-cycle pulse per mismatched beat in LOCKED
//   err_cnt    saturating count of mismatched beats in LOCKED
//   beat_cnt   wrapping count of beats accepted in LOCKED
//
// Optional build macro: PRBS_STREAM_CHECKER_ERR_HALT_EN
//   When defined, the first mismatch in LOCKED sets a halt flag that drops
//   s_ready (from the next cycle) until clr_cnt, freezing the reference at
//   the failing position. When undefined, s_ready is tied high.

module prbs_stream_checker #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] TAPS     = 8'hB8,
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);
    localparam logic [MR_W-1:0] LOCK_CNT_V = MR_W'(LOCK_CNT);
    localparam logic [MS_W-1:0] LOSS_CNT_V = MS_W'(LOSS_CNT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] exp_word;
    logic              have_seed;
    logic [MR_W-1:0]   match_run;
    logic [MS_W-1:0]   miss_run;

    logic              accept;
    logic              word_match;
    logic              locked_miss;
    logic [MR_W-1:0]   match_run_inc;
    logic [MS_W-1:0]   miss_run_inc;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction

    assign accept        = s_valid && s_ready;
    assign word_match    = (s_data == exp_word);
    assign locked_miss   = accept && (state == LOCKED) && !word_match;
    assign match_run_inc = match_run + 1'b1;
    assign miss_run_inc  = miss_run + 1'b1;
    assign locked        = (state == LOCKED);

`ifdef PRBS_STREAM_CHECKER_ERR_HALT_EN
    logic halt;

    // clr_cnt wins over a same-cycle mismatch so software can always release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt <= 1'b0;
        end else if (clr_cnt) begin
            halt <= 1'b0;
        end else if (locked_miss) begin
            halt <= 1'b1;
        end
    end

    assign s_ready = ~halt;
`else
    assign s_ready = 1'b1;
`endif

    // Synchronisation FSM and reference word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            exp_word  <= '0;
            have_seed <= 1'b0;
            match_run <= '0;
            miss_run  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                if (state == SEARCH) begin
                    // Reseed from every received word; a zero word is the
                    // LFSR lockup state and cannot start a run.
                    exp_word  <= lfsr_step(s_data);
                    have_seed <= |s_data;
                    if (have_seed && word_match) begin
                        match_run <= match_run_inc;
                        if (match_run_inc == LOCK_CNT_V) begin
                            state    <= LOCKED;
                            miss_run <= '0;
                        end
                    end else begin
                        match_run <= '0;
                    end
                end else begin
                    // Reference free-runs; never reloaded from s_data here.
                    exp_word <= lfsr_step(exp_word);
                    if (word_match) begin
                        miss_run <= '0;
                    end else begin
                        err_pulse <= 1'b1;
                        if (miss_run_inc == LOSS_CNT_V) begin
                            state     <= SEARCH;
                            match_run <= '0;
                            have_seed <= 1'b0;
                            miss_run  <= '0;
                        end else begin
                            miss_run <= miss_run_inc;
                        end
                    end
                end
            end
        end
    end

    // Statistics counters; clr_cnt has priority over any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            beat_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt  <= '0;
            beat_cnt <= '0;
        end else if (accept && (state == LOCKED)) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (!word_match && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_stream_checker.sv
module tb_prbs_stream_checker;

    localparam int         DATA_W   = 8;
    localparam logic [7:0] TAPS     = 8'hB8;
    localparam int         LOCK_CNT = 4;
    localparam int         LOSS_CNT = 3;
    localparam int         CNT_W    = 32;
    localparam int         CNT_W_S  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              clr_cnt;

    logic              s_ready, locked, err_pulse;
    logic [CNT_W-1:0]  err_cnt, beat_cnt;
    logic              s_ready_s, locked_s, err_pulse_s;
    logic [CNT_W_S-1:0] err_cnt_s, beat_cnt_s;

    always #5 clk = ~clk;

    prbs_stream_checker #(
        .DATA_W(DATA_W), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .clr_cnt(clr_cnt), .locked(locked),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
    );

    prbs_stream_checker #(
        .DATA_W(DATA_W), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W_S)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_s),
        .s_data(s_data), .clr_cnt(clr_cnt), .locked(locked_s),
        .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .beat_cnt(beat_cnt_s)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] step8(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? TAPS : 8'h00);
    endfunction

    // ---------------- behavioural model ----------------
    // SEARCH: keep the words received since entering SEARCH; lock when the
    // newest LOCK_CNT+1 words form an unbroken LFSR chain from a nonzero seed.
    // LOCKED: reference advances once per beat; drop when the newest
    // LOSS_CNT comparisons were all mismatches.
    logic [7:0]  m_hist_q[$];
    bit          m_miss_q[$];
    bit          m_locked = 1'b0;
    logic [7:0]  m_ref    = 8'h00;
    int unsigned m_err    = 0;
    int unsigned m_beat   = 0;
    bit          m_pulse  = 1'b0;
    bit          m_halt   = 1'b0;

    function automatic bit chain_ok();
        for (int i = 0; i < LOCK_CNT; i++) begin
            if (m_hist_q[i] == 8'h00 || m_hist_q[i+1] != step8(m_hist_q[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit all_miss();
        if (m_miss_q.size() < LOSS_CNT) return 1'b0;
        foreach (m_miss_q[i]) if (!m_miss_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist_q.delete();
            m_miss_q.delete();
            m_locked = 1'b0;
            m_ref    = 8'h00;
            m_err    = 0;
            m_beat   = 0;
            m_pulse  = 1'b0;
            m_halt   = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (s_valid && !m_halt) begin
                if (!m_locked) begin
                    m_hist_q.push_back(s_data);
                    if (m_hist_q.size() > LOCK_CNT + 1) void'(m_hist_q.pop_front());
                    if (m_hist_q.size() == LOCK_CNT + 1 && chain_ok()) begin
                        m_locked = 1'b1;
                        m_ref    = step8(s_data);
                        m_miss_q.delete();
                    end
                end else begin
                    bit mism;
                    mism  = (s_data != m_ref);
                    m_ref = step8(m_ref);
                    m_beat++;
                    m_miss_q.push_back(mism);
                    if (m_miss_q.size() > LOSS_CNT) void'(m_miss_q.pop_front());
                    if (mism) begin
                        m_pulse = 1'b1;
                        m_err++;
`ifdef PRBS_STREAM_CHECKER_ERR_HALT_EN
                        m_halt = 1'b1;
`endif
                    end
                    if (all_miss()) begin
                        m_locked = 1'b0;
                        m_hist_q.delete();
                        m_miss_q.delete();
                    end
                end
            end
            if (clr_cnt) begin
                m_err  = 0;
                m_beat = 0;
                m_halt = 1'b0;
            end
        end
    end

    // One compare process, every cycle, both counter widths.
    always @(negedge clk) begin
        int unsigned e_small;
        e_small = (m_err > 15) ? 15 : m_err;
        check("locked",      {31'd0, locked},      {31'd0, m_locked});
        check("err_pulse",   {31'd0, err_pulse},   {31'd0, m_pulse});
        check("s_ready",     {31'd0, s_ready},     {31'd0, !m_halt});
        check("err_cnt",     err_cnt,              m_err);
        check("beat_cnt",    beat_cnt,             m_beat);
        check("locked_s",    {31'd0, locked_s},    {31'd0, m_locked});
        check("err_pulse_s", {31'd0, err_pulse_s}, {31'd0, m_pulse});
        check("s_ready_s",   {31'd0, s_ready_s},   {31'd0, !m_halt});
        check("err_cnt_s",   {28'd0, err_cnt_s},   e_small);
        check("beat_cnt_s",  {28'd0, beat_cnt_s},  m_beat % 16);
    end

    // ---------------- driver tasks ----------------
    logic [7:0] gen;

    task automatic beat(input logic [7:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic good(input int n);
        repeat (n) begin
            beat(gen);
            gen = step8(gen);
        end
    endtask

    task automatic bad();
        beat(gen ^ 8'h01);
        gen = step8(gen);
    endtask

    task automatic clear();
        clr_cnt = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        clr_cnt = 1'b0;
        gen     = 8'h01;
        repeat (3) @(negedge clk);
        check("rst_locked",   {31'd0, locked},  32'd0);
        check("rst_err_cnt",  err_cnt,          32'd0);
        check("rst_beat_cnt", beat_cnt,         32'd0);
        check("rst_s_ready",  {31'd0, s_ready}, 32'd1);
        rst_n = 1'b1;
        idle(1);

`ifndef PRBS_STREAM_CHECKER_ERR_HALT_EN
        // Lock on 01,B8,5C,2E,17
        good(4);
        check("lock_early", {31'd0, locked}, 32'd0);
        good(1);
        check("lock_locked", {31'd0, locked}, 32'd1);
        check("lock_err",    err_cnt,         32'd0);
        check("lock_beat",   beat_cnt,        32'd0);
        check("gen_b3",      {24'd0, gen},    32'h0000_00B3);
        good(1);
        check("b3_beat", beat_cnt, 32'd1);

        // Single error then clean continuation
        bad();
        check("se_pulse",  {31'd0, err_pulse}, 32'd1);
        check("se_err",    err_cnt,            32'd1);
        check("se_locked", {31'd0, locked},    32'd1);
        good(1);
        check("se_pulse_gone", {31'd0, err_pulse}, 32'd0);
        good(4);
        check("se_err_hold", err_cnt,  32'd1);
        check("se_beat",     beat_cnt, 32'd7);

        clear();
        check("clr_err",  err_cnt,  32'd0);
        check("clr_beat", beat_cnt, 32'd0);

        // Loss of lock on three zero words
        beat(8'h00); gen = step8(gen);
        beat(8'h00); gen = step8(gen);
        check("loss_hold", {31'd0, locked}, 32'd1);
        beat(8'h00); gen = step8(gen);
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_err",    err_cnt,         32'd3);

        // Zero words never seed
        repeat (6) beat(8'h00);
        check("zero_noseed", {31'd0, locked}, 32'd0);
        good(5);
        check("relock", {31'd0, locked}, 32'd1);

        // Asynchronous reset while locked
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_err",    err_cnt,         32'd0);
        check("arst_beat",   beat_cnt,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Lock with gaps: exactly 5 accepted beats
        gen = 8'h01;
        for (int i = 0; i < 5; i++) begin
            good(1);
            if (i < 4) check("gap_early", {31'd0, locked}, 32'd0);
            idle(1 + (i % 2));
        end
        check("gap_locked", {31'd0, locked}, 32'd1);
        check("gap_beat",   beat_cnt,        32'd0);

        // Saturation on the 4-bit counter
        repeat (20) begin
            bad();
            good(1);
        end
        check("sat_err_s",  {28'd0, err_cnt_s}, 32'd15);
        check("sat_err",    err_cnt,            32'd20);
        check("sat_locked", {31'd0, locked},    32'd1);

        // clr_cnt coincident with a mismatch
        s_valid = 1'b1;
        s_data  = gen ^ 8'h01;
        clr_cnt = 1'b1;
        @(negedge clk);
        gen     = step8(gen);
        clr_cnt = 1'b0;
        s_valid = 1'b0;
        check("clrmis_err_s", {28'd0, err_cnt_s}, 32'd0);
        check("clrmis_err",   err_cnt,            32'd0);
        check("clrmis_pulse", {31'd0, err_pulse}, 32'd1);
        good(2);
        check("clrmis_after", err_cnt, 32'd0);
`else
        // Halt on first error until clr_cnt
        good(5);
        check("h_locked", {31'd0, locked}, 32'd1);
        bad();
        check("h_pulse", {31'd0, err_pulse}, 32'd1);
        check("h_ready", {31'd0, s_ready},   32'd0);
        repeat (3) beat(gen);
        check("h_ready_hold", {31'd0, s_ready}, 32'd0);
        check("h_beat_frz",   beat_cnt,         32'd1);
        check("h_err_frz",    err_cnt,          32'd1);
        clear();
        check("h_ready_back", {31'd0, s_ready}, 32'd1);
        check("h_err_clr",    err_cnt,          32'd0);
        good(3);
        check("h_resume_err",  err_cnt,  32'd0);
        check("h_resume_beat", beat_cnt, 32'd3);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
